// File: rtl/simmem_wresp_bank.sv
`default_nettype none
// ============================================================================
// Module   : simmem_wresp_bank
// Brief    : Write-response bank; reserves iids, buffers responses per slot and
//            releases them oldest-first under per-slot enables. Optional output
//            register enabled by defining SIMMEM_WRESP_BANK_OUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module simmem_wresp_bank #(
  parameter int Capacity     = 16,
  parameter int IdWidth      = 4,
  parameter int PayloadWidth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [IdWidth-1:0]          rsv_id_i,
  input  logic                        rsv_valid_i,
  output logic                        rsv_ready_o,
  output logic [$clog2(Capacity)-1:0] rsv_iid_o,
  input  logic [IdWidth-1:0]          in_id_i,
  input  logic [PayloadWidth-1:0]     in_payload_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [Capacity-1:0]         release_en_onehot_i,
  output logic [IdWidth-1:0]          out_id_o,
  output logic [PayloadWidth-1:0]     out_payload_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [Capacity-1:0]         released_addr_onehot_o
);

  localparam int IidWidth = $clog2(Capacity);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FILLED   = 2'd2
  } slot_state_e;

  slot_state_e             state_q   [Capacity];
  slot_state_e             state_d   [Capacity];
  logic [IdWidth-1:0]      id_q      [Capacity];
  logic [IdWidth-1:0]      id_d      [Capacity];
  logic [PayloadWidth-1:0] payload_q [Capacity];
  logic [PayloadWidth-1:0] payload_d [Capacity];
  logic [Capacity-1:0]     age_q     [Capacity];
  logic [Capacity-1:0]     age_d     [Capacity];

  logic [Capacity-1:0]     free_mask;
  logic [Capacity-1:0]     cand_mask;
  logic [Capacity-1:0]     elig_mask;
  logic [Capacity-1:0]     rsv_onehot;
  logic [Capacity-1:0]     fill_onehot;
  logic [Capacity-1:0]     elig_oldest;
  logic [Capacity-1:0]     rel_onehot;
  logic [IdWidth-1:0]      sel_id;
  logic [PayloadWidth-1:0] sel_payload;
  logic                    rsv_hs;
  logic                    in_hs;

  always_comb begin
    free_mask = '0;
    cand_mask = '0;
    elig_mask = '0;
    for (int i = 0; i < Capacity; i++) begin
      free_mask[i] = (state_q[i] == SLOT_FREE);
      cand_mask[i] = (state_q[i] == SLOT_RESERVED) && (id_q[i] == in_id_i);
      elig_mask[i] = (state_q[i] == SLOT_FILLED) && release_en_onehot_i[i];
    end
  end

  always_comb begin
    rsv_onehot = '0;
    rsv_iid_o  = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        rsv_onehot    = '0;
        rsv_onehot[i] = 1'b1;
        rsv_iid_o     = IidWidth'(i);
      end
    end
  end

  assign rsv_ready_o = |free_mask;
  assign in_ready_o  = |cand_mask;
  assign rsv_hs      = rsv_valid_i & rsv_ready_o;
  assign in_hs       = in_valid_i & in_ready_o;

  // A slot is the oldest of a set when none of its older slots is in the set.
  always_comb begin
    fill_onehot = '0;
    elig_oldest = '0;
    sel_id      = '0;
    sel_payload = '0;
    for (int i = 0; i < Capacity; i++) begin
      fill_onehot[i] = cand_mask[i] && ((age_q[i] & cand_mask) == '0);
      elig_oldest[i] = elig_mask[i] && ((age_q[i] & elig_mask) == '0);
      if (elig_oldest[i]) begin
        sel_id      = id_q[i];
        sel_payload = payload_q[i];
      end
    end
  end

`ifdef SIMMEM_WRESP_BANK_OUT_REG_EN
  logic                    oreg_valid_q, oreg_valid_d;
  logic [IdWidth-1:0]      oreg_id_q, oreg_id_d;
  logic [PayloadWidth-1:0] oreg_payload_q, oreg_payload_d;
  logic                    pop;

  always_comb begin
    pop            = (|elig_mask) && (!oreg_valid_q || out_ready_i);
    oreg_valid_d   = oreg_valid_q;
    oreg_id_d      = oreg_id_q;
    oreg_payload_d = oreg_payload_q;
    if (pop) begin
      oreg_valid_d   = 1'b1;
      oreg_id_d      = sel_id;
      oreg_payload_d = sel_payload;
    end else if (out_ready_i) begin
      oreg_valid_d   = 1'b0;
    end
    rel_onehot = pop ? elig_oldest : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oreg_valid_q   <= 1'b0;
      oreg_id_q      <= '0;
      oreg_payload_q <= '0;
    end else begin
      oreg_valid_q   <= oreg_valid_d;
      oreg_id_q      <= oreg_id_d;
      oreg_payload_q <= oreg_payload_d;
    end
  end

  assign out_valid_o   = oreg_valid_q;
  assign out_id_o      = oreg_id_q;
  assign out_payload_o = oreg_payload_q;
`else
  always_comb begin
    out_valid_o   = |elig_mask;
    out_id_o      = sel_id;
    out_payload_o = sel_payload;
    rel_onehot    = (out_valid_o && out_ready_i) ? elig_oldest : '0;
  end
`endif

  assign released_addr_onehot_o = rel_onehot;

  // Released and filled slots are never free, so the reserved slot cannot collide.
  always_comb begin
    for (int i = 0; i < Capacity; i++) begin
      state_d[i]   = state_q[i];
      id_d[i]      = id_q[i];
      payload_d[i] = payload_q[i];
      age_d[i]     = age_q[i];
      if (rel_onehot[i]) begin
        state_d[i] = SLOT_FREE;
      end
      if (in_hs && fill_onehot[i]) begin
        state_d[i]   = SLOT_FILLED;
        payload_d[i] = in_payload_i;
      end
      if (rsv_hs && rsv_onehot[i]) begin
        state_d[i] = SLOT_RESERVED;
        id_d[i]    = rsv_id_i;
        age_d[i]   = ~free_mask;
      end
      age_d[i] = age_d[i] & ~rel_onehot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i]   <= SLOT_FREE;
        id_q[i]      <= '0;
        payload_q[i] <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i]   <= state_d[i];
        id_q[i]      <= id_d[i];
        payload_q[i] <= payload_d[i];
        age_q[i]     <= age_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simmem_wresp_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_simmem_wresp_bank
// Brief    : Self-checking bench for simmem_wresp_bank (combinational output build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simmem_wresp_bank;
  localparam int CAP = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      rsv_id = '0;
  logic            rsv_valid = 1'b0;
  logic            rsv_ready;
  logic [3:0]      rsv_iid;
  logic [3:0]      in_id = '0;
  logic [1:0]      in_payload = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CAP-1:0]  release_en = '0;
  logic [3:0]      out_id;
  logic [1:0]      out_payload;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CAP-1:0]  released;

  int tests = 0;
  int fails = 0;

  // Reference model: slot status 0=free 1=reserved 2=filled, age via reservation sequence
  int m_state [CAP];
  int m_id    [CAP];
  int m_pay   [CAP];
  int m_seq   [CAP];
  int seq_ctr;

  simmem_wresp_bank #(.Capacity(CAP), .IdWidth(4), .PayloadWidth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsv_id_i(rsv_id), .rsv_valid_i(rsv_valid), .rsv_ready_o(rsv_ready), .rsv_iid_o(rsv_iid),
    .in_id_i(in_id), .in_payload_i(in_payload), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .release_en_onehot_i(release_en),
    .out_id_o(out_id), .out_payload_o(out_payload), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .released_addr_onehot_o(released)
  );

  always #5 clk = ~clk;

  function automatic int m_lowest_free();
    for (int i = 0; i < CAP; i++) if (m_state[i] == 0) return i;
    return -1;
  endfunction

  function automatic int m_oldest_cand(input int id);
    int best = -1;
    for (int i = 0; i < CAP; i++)
      if (m_state[i] == 1 && m_id[i] == id && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction

  function automatic int m_oldest_elig(input logic [CAP-1:0] en);
    int best = -1;
    for (int i = 0; i < CAP; i++)
      if (m_state[i] == 2 && en[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rsv_valid = 1'b0; rsv_id = '0; in_valid = 1'b0; in_id = '0; in_payload = '0;
    release_en = '0; out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    adv();
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      m_state[i] = 0; m_id[i] = 0; m_pay[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL reset_rsv_ready: got %b expected 1", rsv_ready); end
    tests++; if (rsv_iid !== 4'd0) begin fails++; $display("FAIL reset_rsv_iid: got %0d expected 0", rsv_iid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (released !== 16'h0) begin fails++; $display("FAIL reset_released: got %h expected 0000", released); end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    rsv_valid = 1'b1; rsv_id = 4'd3;
    @(negedge clk);
    tests++; if (rsv_iid !== 4'd0) begin fails++; $display("FAIL basic_iid: got %0d expected 0", rsv_iid); end
    adv();
    rsv_valid = 1'b0; in_valid = 1'b1; in_id = 4'd3; in_payload = 2'b00;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_no_out: got %b expected 0", out_valid); end
    adv();
    in_valid = 1'b0; release_en = 16'h0001;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_id !== 4'd3 || out_payload !== 2'b00) begin
      fails++; $display("FAIL basic_out: got v=%b id=%0d p=%b expected v=1 id=3 p=00", out_valid, out_id, out_payload); end
    tests++; if (released !== 16'h0) begin fails++; $display("FAIL basic_no_release: got %h expected 0000", released); end
    adv();
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (released !== 16'h0001) begin fails++; $display("FAIL basic_release: got %h expected 0001", released); end
    adv();
    idle_inputs();
    @(negedge clk);
    tests++; if (rsv_iid !== 4'd0 || rsv_ready !== 1'b1) begin
      fails++; $display("FAIL basic_reissue: got iid=%0d rdy=%b expected iid=0 rdy=1", rsv_iid, rsv_ready); end
    adv();
  endtask

  task automatic test_same_id();
    logic [1:0] pays [2];
    pays[0] = 2'b10; pays[1] = 2'b01;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      rsv_valid = 1'b1; rsv_id = 4'd5;
      @(negedge clk);
      tests++; if (rsv_iid !== 4'(k)) begin fails++; $display("FAIL sameid_iid%0d: got %0d expected %0d", k, rsv_iid, k); end
      adv();
    end
    rsv_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_id = 4'd5; in_payload = pays[k];
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sameid_in_ready%0d: got %b expected 1", k, in_ready); end
      adv();
    end
    in_valid = 1'b0; release_en = 16'h0003; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_payload !== pays[k] || released !== 16'(1 << k)) begin
        fails++; $display("FAIL sameid_out%0d: got v=%b p=%b rel=%h expected v=1 p=%b rel=%h",
                          k, out_valid, out_payload, released, pays[k], 16'(1 << k)); end
      adv();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < CAP; k++) begin
      rsv_valid = 1'b1; rsv_id = 4'(k);
      @(negedge clk);
      tests++; if (rsv_iid !== 4'(k) || rsv_ready !== 1'b1) begin
        fails++; $display("FAIL full_fill%0d: got iid=%0d rdy=%b expected iid=%0d rdy=1", k, rsv_iid, rsv_ready, k); end
      adv();
    end
    rsv_valid = 1'b0; in_valid = 1'b1; in_id = 4'd7; in_payload = 2'b11;
    @(negedge clk);
    tests++; if (rsv_ready !== 1'b0) begin fails++; $display("FAIL full_not_ready: got %b expected 0", rsv_ready); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready: got %b expected 1", in_ready); end
    adv();
    in_valid = 1'b0; release_en = 16'h0080; out_ready = 1'b1;
    @(negedge clk);
    tests++; if (released !== 16'h0080 || rsv_ready !== 1'b0) begin
      fails++; $display("FAIL full_release: got rel=%h rdy=%b expected rel=0080 rdy=0", released, rsv_ready); end
    adv();
    idle_inputs();
    @(negedge clk);
    tests++; if (rsv_ready !== 1'b1 || rsv_iid !== 4'd7) begin
      fails++; $display("FAIL full_reopen: got rdy=%b iid=%0d expected rdy=1 iid=7", rsv_ready, rsv_iid); end
    adv();
  endtask

  task automatic test_unmatched();
    apply_reset();
    in_valid = 1'b1; in_id = 4'd9; in_payload = 2'b01;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL unmatched_stall: got %b expected 0", in_ready); end
    adv();
    rsv_valid = 1'b1; rsv_id = 4'd9;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL unmatched_same_cycle: got %b expected 0", in_ready); end
    adv();
    rsv_valid = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL unmatched_next_cycle: got %b expected 1", in_ready); end
    adv();
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      rsv_valid = 1'b1; rsv_id = 4'(k);
      adv();
    end
    rsv_valid = 1'b0; in_valid = 1'b1; in_id = 4'd2; in_payload = 2'b11;
    adv();
    in_valid = 1'b0; release_en = 16'h0004; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_id !== 4'd2 || out_payload !== 2'b11 || released !== 16'h0) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b id=%0d p=%b rel=%h expected v=1 id=2 p=11 rel=0000",
                          k, out_valid, out_id, out_payload, released); end
      adv();
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (released !== 16'h0004) begin fails++; $display("FAIL bp_pulse: got %h expected 0004", released); end
    adv();
    @(negedge clk);
    tests++; if (released !== 16'h0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_single: got rel=%h v=%b expected rel=0000 v=0", released, out_valid); end
    adv();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      rsv_valid = 1'b1; rsv_id = 4'(k + 1);
      adv();
    end
    rsv_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_id = 4'(k + 1); in_payload = 2'(k);
      adv();
    end
    in_valid = 1'b0; release_en = 16'hFFFF; out_ready = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || rsv_iid !== 4'd3) begin
      fails++; $display("FAIL rmid_pre: got v=%b iid=%0d expected v=1 iid=3", out_valid, rsv_iid); end
    adv();
    rst_n = 1'b0; in_valid = 1'b1; in_id = 4'd1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || rsv_iid !== 4'd0 || rsv_ready !== 1'b1 || in_ready !== 1'b0 || released !== 16'h0) begin
      fails++; $display("FAIL rmid_reset: got v=%b iid=%0d rdy=%b inr=%b rel=%h expected v=0 iid=0 rdy=1 inr=0 rel=0000",
                        out_valid, rsv_iid, rsv_ready, in_ready, released); end
    adv();
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_lost: got v=%b inr=%b expected v=0 inr=0", out_valid, in_ready); end
    adv();
    idle_inputs();
  endtask

  task automatic test_random();
    int lf, cand, el;
    logic [CAP-1:0] exp_rel;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rsv_valid  = ($urandom_range(0, 99) < 55);
      rsv_id     = 4'($urandom_range(0, 3));
      in_valid   = ($urandom_range(0, 99) < 60);
      in_id      = 4'($urandom_range(0, 3));
      in_payload = 2'($urandom_range(0, 3));
      release_en = 16'($urandom()) & 16'($urandom());
      out_ready  = ($urandom_range(0, 99) < 60);
      lf   = m_lowest_free();
      cand = m_oldest_cand(int'(in_id));
      el   = m_oldest_elig(release_en);
      exp_rel = (el >= 0 && out_ready) ? 16'(1 << el) : 16'h0;
      @(negedge clk);
      tests++; if (rsv_ready !== (lf >= 0)) begin
        fails++; $display("FAIL rnd_rsv_ready c%0d: got %b expected %b", cyc, rsv_ready, (lf >= 0)); end
      if (lf >= 0) begin
        tests++; if (rsv_iid !== 4'(lf)) begin
          fails++; $display("FAIL rnd_rsv_iid c%0d: got %0d expected %0d", cyc, rsv_iid, lf); end
      end
      tests++; if (in_ready !== (cand >= 0)) begin
        fails++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", cyc, in_ready, (cand >= 0)); end
      tests++; if (out_valid !== (el >= 0)) begin
        fails++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", cyc, out_valid, (el >= 0)); end
      if (el >= 0) begin
        tests++; if (out_id !== 4'(m_id[el]) || out_payload !== 2'(m_pay[el])) begin
          fails++; $display("FAIL rnd_out_data c%0d: got id=%0d p=%0d expected id=%0d p=%0d",
                            cyc, out_id, out_payload, m_id[el], m_pay[el]); end
      end
      tests++; if (released !== exp_rel) begin
        fails++; $display("FAIL rnd_released c%0d: got %h expected %h", cyc, released, exp_rel); end
      if (el >= 0 && out_ready) m_state[el] = 0;
      if (in_valid && cand >= 0) begin
        m_state[cand] = 2; m_pay[cand] = int'(in_payload);
      end
      if (rsv_valid && lf >= 0) begin
        m_state[lf] = 1; m_id[lf] = int'(rsv_id); m_seq[lf] = seq_ctr; seq_ctr++;
      end
      adv();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_id();
    test_full();
    test_unmatched();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
